// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the CPU MEM stage and an external burst master share one memory port.
// Optional alignment checking is enabled by defining DMEM_ARB_ALIGN_CHK_EN.
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [3:0]  ext_len,
  input  logic [31:0] ext_wdata,
  output logic        ext_gnt,
  output logic        ext_beat,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  output logic        ext_done,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
`ifdef DMEM_ARB_ALIGN_CHK_EN
  ,
  output logic        align_err
`endif
);

  localparam int WW = $clog2(STARVE_LIMIT + 2);
  localparam logic [WW-1:0] LIMIT = WW'(STARVE_LIMIT);

  typedef enum logic {IDLE, EXT_BUSY} state_t;

  state_t        state, state_next;
  logic [WW-1:0] wait_cnt;
  logic [3:0]    beat_idx;
  logic [3:0]    len_l;
  logic [31:0]   base;
  logic          we_l;
  logic          cpu_req;
  logic          busy;
  logic          ext_win;
  logic          last_beat;
  logic          cpu_mis;
  logic          ext_mis;
  logic [31:0]   beat_addr;

  assign cpu_req   = cpu_rd | cpu_wr;
  assign busy      = (state == EXT_BUSY);
  assign last_beat = (beat_idx == len_l);
  // The external master wins when the CPU is quiet or it has lost too often.
  assign ext_win   = reset & ~busy & ext_req & (~cpu_req | (wait_cnt >= LIMIT));
  assign beat_addr = (base + {26'd0, beat_idx, 2'b00}) & 32'h0000_007F;

`ifdef DMEM_ARB_ALIGN_CHK_EN
  assign cpu_mis = (cpu_addr[1:0] != 2'b00);
  assign ext_mis = (base[1:0] != 2'b00);
`else
  assign cpu_mis = 1'b0;
  assign ext_mis = 1'b0;
`endif

  always_comb begin
    state_next = state;
    ext_gnt    = 1'b0;
    ext_beat   = 1'b0;
    cpu_stall  = 1'b0;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    cpu_rdata  = mem_rdata;
    case (state)
      IDLE: begin
        if (ext_win) begin
          ext_gnt    = 1'b1;
          cpu_stall  = cpu_req;
          state_next = EXT_BUSY;
        end else begin
          mem_read  = cpu_rd;
          mem_write = cpu_wr & ~cpu_mis;
        end
      end
      EXT_BUSY: begin
        ext_beat  = 1'b1;
        cpu_stall = cpu_req;
        mem_addr  = beat_addr;
        mem_wdata = ext_wdata;
        mem_write = we_l & ~ext_mis;
        mem_read  = ~we_l;
        if (last_beat) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Memory strobes and handshakes stay quiet for the whole reset interval.
    if (!reset) begin
      ext_gnt   = 1'b0;
      ext_beat  = 1'b0;
      cpu_stall = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      beat_idx   <= 4'd0;
      len_l      <= 4'd0;
      base       <= 32'd0;
      we_l       <= 1'b0;
      ext_rvalid <= 1'b0;
      ext_done   <= 1'b0;
      ext_rdata  <= 32'd0;
    end else begin
      state      <= state_next;
      ext_rvalid <= busy & ~we_l;
      ext_done   <= busy & last_beat;
      if (busy && !we_l) ext_rdata <= mem_rdata;
      if (ext_win) begin
        base     <= ext_addr;
        we_l     <= ext_we;
        len_l    <= ext_len;
        beat_idx <= 4'd0;
        wait_cnt <= '0;
      end else if (!busy && ext_req && wait_cnt != LIMIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
      if (busy) beat_idx <= beat_idx + 4'd1;
    end
  end

`ifdef DMEM_ARB_ALIGN_CHK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      align_err <= 1'b0;
    end else if ((~busy & ~ext_win & cpu_req & cpu_mis) | (busy & ext_mis)) begin
      align_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios with literal expectations plus a
// queue-based reference model compared against the outputs every negative clock edge.
module tb_dmem_arbiter;

  localparam int STARVE = 4;
`ifdef DMEM_ARB_ALIGN_CHK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr;
  logic [3:0]  ext_len;
  logic [31:0] ext_wdata;
  logic        ext_gnt, ext_beat, ext_rvalid, ext_done;
  logic [31:0] ext_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;
`ifdef DMEM_ARB_ALIGN_CHK_EN
  logic        align_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  dmem_arbiter #(.STARVE_LIMIT(STARVE)) dut (
    .clk(clk), .reset(reset),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_len(ext_len),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt), .ext_beat(ext_beat),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata), .ext_done(ext_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_ALIGN_CHK_EN
    , .align_err(align_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 128-byte data memory with combinational read
  logic [31:0] mem [32];
  assign mem_rdata = mem[mem_addr[6:2]];
  always @(posedge clk) if (mem_write) mem[mem_addr[6:2]] <= mem_wdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
  } beat_t;

  beat_t       beat_q[$];
  beat_t       m_b;
  logic [31:0] ref_mem [32];
  int          losses;
  logic        m_rvalid, m_done, m_align, m_base_mis;
  logic [31:0] m_rdata;
  logic        n_rvalid, n_done, n_align;
  logic [31:0] n_rdata;
  logic        m_req, m_win, m_wr, m_mis;

  always @(negedge clk) begin
    if (!reset) begin
      check("rst_mem_write", mem_write, 0);
      check("rst_mem_read", mem_read, 0);
      check("rst_cpu_stall", cpu_stall, 0);
      check("rst_ext_gnt", ext_gnt, 0);
      check("rst_rvalid", ext_rvalid, 0);
      check("rst_done", ext_done, 0);
      check("rst_rdata", ext_rdata, 0);
`ifdef DMEM_ARB_ALIGN_CHK_EN
      check("rst_align_err", align_err, 0);
`endif
      beat_q.delete();
      losses = 0;
      m_rvalid = 0; m_done = 0; m_rdata = 0; m_align = 0; m_base_mis = 0;
    end else begin
      check("m_rvalid", ext_rvalid, m_rvalid);
      check("m_rdata", ext_rdata, m_rdata);
      check("m_done", ext_done, m_done);
`ifdef DMEM_ARB_ALIGN_CHK_EN
      check("m_align_err", align_err, m_align);
`endif
      n_rvalid = 0; n_done = 0; n_rdata = m_rdata; n_align = m_align;
      m_req = cpu_rd | cpu_wr;
      if (beat_q.size() == 0) begin
        m_win = ext_req && (!m_req || losses >= STARVE);
        check("m_gnt", ext_gnt, m_win);
        check("m_beat_idle", ext_beat, 0);
        check("m_stall_idle", cpu_stall, m_req && m_win);
        if (m_win) begin
          check("m_win_read", mem_read, 0);
          check("m_win_write", mem_write, 0);
          for (int k = 0; k <= int'(ext_len); k++)
            beat_q.push_back('{addr: (ext_addr + 32'(4 * k)) & 32'h7F, we: ext_we});
          m_base_mis = ALIGN && (ext_addr[1:0] != 2'b00);
          losses = 0;
        end else begin
          m_mis = ALIGN && (cpu_addr[1:0] != 2'b00);
          m_wr  = cpu_wr && !m_mis;
          check("m_cpu_read", mem_read, cpu_rd);
          check("m_cpu_write", mem_write, m_wr);
          if (m_req) check("m_cpu_addr", mem_addr, cpu_addr);
          if (cpu_wr) check("m_cpu_wdata", mem_wdata, cpu_wdata);
          if (cpu_rd) check("m_cpu_rdata", cpu_rdata, ref_mem[cpu_addr[6:2]]);
          if (m_wr) ref_mem[cpu_addr[6:2]] = cpu_wdata;
          if (m_req && m_mis) n_align = 1;
          if (ext_req && losses < STARVE) losses++;
        end
      end else begin
        m_b = beat_q.pop_front();
        check("m_beat", ext_beat, 1);
        check("m_gnt_busy", ext_gnt, 0);
        check("m_stall_busy", cpu_stall, m_req);
        check("m_beat_addr", mem_addr, m_b.addr);
        check("m_beat_read", mem_read, !m_b.we);
        check("m_beat_write", mem_write, m_b.we && !m_base_mis);
        if (m_b.we) begin
          check("m_beat_wdata", mem_wdata, ext_wdata);
          if (!m_base_mis) ref_mem[m_b.addr[6:2]] = ext_wdata;
        end else begin
          n_rvalid = 1;
          n_rdata  = ref_mem[m_b.addr[6:2]];
        end
        if (m_base_mis) n_align = 1;
        if (beat_q.size() == 0) n_done = 1;
      end
      m_rvalid = n_rvalid; m_done = n_done; m_rdata = n_rdata; m_align = n_align;
    end
  end

  // ---------------- directed stimulus ----------------
  int gnt_cycle;

  initial begin
    for (int k = 0; k < 32; k++) begin
      mem[k]     = {16'hA5A5, 8'(k), 8'(k)};
      ref_mem[k] = {16'hA5A5, 8'(k), 8'(k)};
    end
    mem[5] = 32'h0000_006D;  ref_mem[5] = 32'h0000_006D;
    mem[6] = 32'hCAFE_0006;  ref_mem[6] = 32'hCAFE_0006;

    reset = 1'b1;
    cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_len = 0; ext_wdata = 0;
    #1 reset = 1'b0;

    // requests presented during reset must not reach memory
    tick();
    cpu_wr = 1; cpu_addr = 32'd8; ext_req = 1;
    #1;
    check("reset_mem_write", mem_write, 0);
    check("reset_stall", cpu_stall, 0);
    check("reset_gnt", ext_gnt, 0);
    check("reset_rvalid", ext_rvalid, 0);
    tick();
    cpu_wr = 0; ext_req = 0;
    #2 reset = 1'b1;
    tick();

    // CPU-only store: zero-latency pass-through
    tick();
    cpu_wr = 1; cpu_addr = 32'd100; cpu_wdata = 32'h1FF;
    #1;
    check("cpu_wr_mem_write", mem_write, 1);
    check("cpu_wr_mem_addr", mem_addr, 32'd100);
    check("cpu_wr_mem_wdata", mem_wdata, 32'h1FF);
    check("cpu_wr_stall", cpu_stall, 0);
    tick();
    cpu_wr = 0;

    // external read burst at 20, two beats
    tick();
    ext_req = 1; ext_we = 0; ext_addr = 32'd20; ext_len = 4'd1;
    #1;
    check("rd_gnt", ext_gnt, 1);
    check("rd_gnt_mem_read", mem_read, 0);
    tick();
    ext_req = 0;
    #1;
    check("rd_gnt_one_cycle", ext_gnt, 0);
    check("rd_beat0_addr", mem_addr, 32'd20);
    check("rd_beat0_read", mem_read, 1);
    tick(); #1;
    check("rd_beat1_addr", mem_addr, 32'd24);
    check("rd_rvalid0", ext_rvalid, 1);
    check("rd_rdata0", ext_rdata, 32'h6D);
    check("rd_done_early", ext_done, 0);
    tick(); #1;
    check("rd_rvalid1", ext_rvalid, 1);
    check("rd_rdata1", ext_rdata, 32'hCAFE_0006);
    check("rd_done", ext_done, 1);
    check("rd_beat_end", ext_beat, 0);
    tick(); #1;
    check("rd_done_pulse", ext_done, 0);
    check("rd_rvalid_end", ext_rvalid, 0);

    // contention: CPU wins four cycles, external write burst then stalls it
    tick();
    cpu_rd = 1; cpu_addr = 32'd8;
    ext_req = 1; ext_we = 1; ext_addr = 32'h40; ext_len = 4'd2; ext_wdata = 0;
    gnt_cycle = 0;
    for (int c = 1; c <= 12; c++) begin
      #1;
      if (ext_gnt === 1'b1) begin
        gnt_cycle = c;
        break;
      end
      check("cont_cpu_no_stall", cpu_stall, 0);
      tick();
    end
    check("cont_gnt_cycle", gnt_cycle, 5);
    check("cont_gnt_stall", cpu_stall, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      ext_req = 0; ext_wdata = 32'hB000_0000 + 32'(k);
      #1;
      check("cont_burst_stall", cpu_stall, 1);
      check("cont_burst_write", mem_write, 1);
      check("cont_burst_addr", mem_addr, 32'h40 + 32'(4 * k));
    end
    tick(); #1;
    check("cont_after_stall", cpu_stall, 0);
    check("cont_after_read", mem_read, 1);
    tick();
    cpu_rd = 0;

    // wrap inside 128 bytes
    tick();
    ext_req = 1; ext_we = 1; ext_addr = 32'h7C; ext_len = 4'd1;
    #1;
    check("wrap_gnt", ext_gnt, 1);
    tick();
    ext_req = 0; ext_wdata = 32'hC1;
    #1;
    check("wrap_addr0", mem_addr, 32'h7C);
    tick();
    ext_wdata = 32'hC2;
    #1;
    check("wrap_addr1", mem_addr, 32'h00);
    tick(); tick();

    // back-to-back: a new grant in the ext_done cycle
    tick();
    ext_req = 1; ext_we = 0; ext_addr = 32'h40; ext_len = 4'd0;
    #1;
    check("b2b_gnt0", ext_gnt, 1);
    tick(); #1;
    check("b2b_beat0_addr", mem_addr, 32'h40);
    tick(); #1;
    check("b2b_done0", ext_done, 1);
    check("b2b_gnt1", ext_gnt, 1);
    check("b2b_rdata0", ext_rdata, 32'hB000_0000);
    tick();
    ext_req = 0;
    #1;
    check("b2b_beat1", ext_beat, 1);
    tick(); #1;
    check("b2b_done1", ext_done, 1);
    tick();

    // reset during beat 2 of an eight-beat write burst
    tick();
    ext_req = 1; ext_we = 1; ext_addr = 32'h0; ext_len = 4'd7; ext_wdata = 32'hD0;
    #1;
    check("rstb_gnt", ext_gnt, 1);
    tick();
    ext_req = 0;
    tick();
    tick(); #1;
    check("rstb_beat2_addr", mem_addr, 32'h8);
    check("rstb_beat2_write", mem_write, 1);
    #1 reset = 1'b0;
    #1;
    check("rstb_write_cut", mem_write, 0);
    check("rstb_beat_cut", ext_beat, 0);
    tick();
    tick();
    #2 reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick(); #1;
      check("rstb_no_done", ext_done, 0);
      check("rstb_no_beat", ext_beat, 0);
    end

`ifdef DMEM_ARB_ALIGN_CHK_EN
    tick();
    cpu_wr = 1; cpu_addr = 32'h66; cpu_wdata = 32'h55;
    #1;
    check("align_write_blocked", mem_write, 0);
    tick();
    cpu_wr = 0;
    #1;
    check("align_err_set", align_err, 1);
    tick();
`endif

    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL be clocked on `clk` (one clock) with `reset` asynchronous and active-low.
REQ-002 Parameter STARVE_LIMIT, default 4: maximum number of cycles a pending external request may lose to the CPU.
REQ-003 Port list (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  async active-low reset
- cpu_rd  in  1  MEM-stage memRead
- cpu_wr  in  1  MEM-stage memWrite
- cpu_addr  in  32  MEM-stage address
- cpu_wdata  in  32  MEM-stage store data
- cpu_rdata  out  32  load data to MEM/WB
- cpu_stall  out  1  freeze whole pipeline: PCWrite low, all pipeline registers hold
- ext_req  in  1  external loader/debug burst request
- ext_we  in  1  burst is write (1) or read (0)
- ext_addr  in  32  burst base byte address
- ext_len  in  4  beats minus one
- ext_wdata  in  32  write data for current beat
- ext_gnt  out  1  burst accepted
- ext_beat  out  1  a beat executes this cycle
- ext_rvalid  out  1  ext_rdata valid
- ext_rdata  out  32  registered read data
- ext_done  out  1  burst complete
- mem_addr  out  32  to data memory
- mem_wdata  out  32  to data memory
- mem_read  out  1  to data memory
- mem_write  out  1  to data memory
- mem_rdata  in  32  from data memory (combinational read)

Function
REQ-004 FSM states: IDLE, EXT_BUSY.
REQ-005 In IDLE, define cpu_req = cpu_rd|cpu_wr and ext_win = ext_req & (!cpu_req | wait_cnt >= STARVE_LIMIT).
REQ-006 wait_cnt: saturating counter. Increments each cycle in which ext_req=1 and ext_win=0. Clears on ext_win.
REQ-007 ext_gnt = ext_win (combinational, one cycle). On that edge: base, ext_we and ext_len are latched, beat index i is cleared to 0, and the FSM moves to EXT_BUSY.
REQ-008 In IDLE with ext_win=0, the CPU owns memory: mem_* = cpu_* pass-through; cpu_rdata = mem_rdata in the same cycle (zero added latency).
REQ-009 In the ext_win cycle, mem_read and mem_write SHALL be 0.
REQ-010 In EXT_BUSY, each cycle is one beat:
- ext_beat = 1
- mem_addr = (base + 4*i) & 32'h7F, so the address wraps inside the 128-byte memory
- mem_write = latched we; mem_read = !latched we
- mem_wdata = ext_wdata
REQ-011 Read beats SHALL register mem_rdata into ext_rdata and assert ext_rvalid on the following cycle.
REQ-012 After beat i = latched ext_len, the FSM returns to IDLE, and ext_done pulses for one cycle in the next cycle, coincident with the last ext_rvalid for a read burst.
REQ-013 cpu_stall = cpu_req & (ext_win | state==EXT_BUSY). The CPU is never granted memory while cpu_stall=1. Non-memory instructions are not stalled.
REQ-014 Deasserting ext_req mid-burst SHALL have no effect. A burst cannot be aborted except by reset.
REQ-015 A new ext_win SHALL be evaluated in the cycle ext_done is high; back-to-back bursts are allowed.
REQ-016 While ext_we=1, write beats SHALL leave ext_rdata and ext_rvalid unchanged.

Reset
REQ-017 On reset low, the following SHALL be forced immediately: state=IDLE, wait_cnt=0, i=0, ext_rvalid=0, ext_done=0, ext_rdata=0.
REQ-018 While reset is low, mem_write=0, mem_read=0, cpu_stall=0 and ext_gnt=0.
REQ-019 Reset asserted mid-burst aborts the burst: no further beats, no ext_done.

Configuration
REQ-020 With DMEM_ARB_ALIGN_CHK_EN defined: any CPU or external access with addr[1:0] != 0 SHALL have mem_write suppressed. This applies both to the access itself and to the whole external burst when base[1:0] != 0.
REQ-021 With DMEM_ARB_ALIGN_CHK_EN defined: a registered sticky output align_err (1 bit, reset 0) SHALL be set by any such access.
REQ-022 Without the macro, no alignment check is performed and the align_err port SHALL be absent.

Verification
REQ-023 Scenario, CPU only: cpu_wr=1, cpu_addr=100, cpu_wdata=0x1FF -> mem_write=1 and mem_addr=100 in the same cycle; cpu_stall=0.
REQ-024 Scenario, external read burst: ext_req=1, ext_we=0, ext_addr=20, ext_len=1 with memory idle -> ext_gnt for 1 cycle; beats at 20 and 24; ext_rvalid on the 2 following cycles with ext_rdata 0x6D then word@24; ext_done with the second rvalid.
REQ-025 Scenario, contention: cpu_rd held high and ext_req held high -> the CPU wins 4 cycles, ext_gnt on the 5th cycle, then cpu_stall=1 through the whole burst.
REQ-026 Scenario, wrap: ext write, ext_addr=0x7C, ext_len=1 -> beat addresses 0x7C then 0x00.
REQ-027 Scenario, reset mid-burst: reset low during beat 2 of ext_len=7 -> mem_write=0 immediately, state=IDLE, no ext_done.
REQ-028 Scenario, with DMEM_ARB_ALIGN_CHK_EN: cpu_wr at addr 0x66 -> mem_write=0 and align_err=1 the next cycle.
